// File: rtl/data_serializer.sv
// data_serializer: captures four parallel words on a start pulse and emits
// them byte 0 first on one bus, each marked by a one-cycle low data_ready.
// Latency: start edge E0 -> byte0 strobe after E1; byte n strobe after E(1+n)+n*GAP.
// Backpressure: hold=1 freezes emission and gap counting; start while busy is dropped.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           frame request, sampled only while idle
//   datain0..3      words captured at start, emitted in index order
//   hold            stall; no emission or gap countdown on that edge
//   dataout         registered byte bus, keeps the last emitted byte
//   data_ready      registered active-low byte strobe
//   busy            registered frame-in-progress flag
//   done            registered one-cycle pulse after the last byte
module data_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] datain0,
  input  logic [WIDTH-1:0] datain1,
  input  logic [WIDTH-1:0] datain2,
  input  logic [WIDTH-1:0] datain3,
  input  logic             hold,
  output logic [WIDTH-1:0] dataout,
  output logic             data_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(GAP);

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [7:0]       gap_cnt, gap_cnt_nxt;
  logic [WIDTH-1:0] shadow [4];
  logic [WIDTH-1:0] shadow_nxt [4];
  logic [WIDTH-1:0] dataout_nxt;
  logic             data_ready_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      gap_cnt    <= 8'd0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
      dataout    <= '0;
      data_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      gap_cnt    <= gap_cnt_nxt;
      for (int i = 0; i < 4; i++) shadow[i] <= shadow_nxt[i];
      dataout    <= dataout_nxt;
      data_ready <= data_ready_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    // Strobe idles high and done is a pulse, so both default to inactive;
    // everything else holds unless a state explicitly moves it.
    state_nxt      = state;
    idx_nxt        = idx;
    gap_cnt_nxt    = gap_cnt;
    for (int i = 0; i < 4; i++) shadow_nxt[i] = shadow[i];
    dataout_nxt    = dataout;
    data_ready_nxt = 1'b1;
    busy_nxt       = busy;
    done_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          // Snapshot the words so the source may change them mid-frame.
          shadow_nxt[0] = datain0;
          shadow_nxt[1] = datain1;
          shadow_nxt[2] = datain2;
          shadow_nxt[3] = datain3;
          idx_nxt       = 2'd0;
          gap_cnt_nxt   = 8'd0;
          busy_nxt      = 1'b1;
          state_nxt     = SEND;
        end
      end

      SEND: begin
        if (hold) begin
          // Stall: nothing advances, strobe stays high.
        end else if (gap_cnt != 8'd0) begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end else begin
          dataout_nxt    = shadow[idx];
          data_ready_nxt = 1'b0;
          if (idx == 2'd3) begin
            state_nxt = FINISH;
          end else begin
            idx_nxt     = idx + 2'd1;
            gap_cnt_nxt = GAP_LOAD;
          end
        end
      end

      FINISH: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_serializer.sv
// Directed bench for data_serializer: instance a uses GAP=0, instance b GAP=2.
module tb_data_serializer;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic       hold_a, hold_b;
  logic [7:0] din0, din1, din2, din3;
  logic [7:0] dout_a, dout_b;
  logic       dr_a, dr_b, busy_a, busy_b, done_a, done_b;

  int total;
  int passed;

  data_serializer #(.WIDTH(8), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .datain0(din0), .datain1(din1), .datain2(din2), .datain3(din3),
    .hold(hold_a), .dataout(dout_a), .data_ready(dr_a), .busy(busy_a), .done(done_a)
  );

  data_serializer #(.WIDTH(8), .GAP(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .datain0(din0), .datain1(din1), .datain2(din2), .datain3(din3),
    .hold(hold_b), .dataout(dout_b), .data_ready(dr_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic exp_a(input string tag, input logic dr, input logic [7:0] dout,
                       input logic bsy, input logic dn);
    chk({tag, ".data_ready"}, 32'(dr_a), 32'(dr));
    chk({tag, ".dataout"}, 32'(dout_a), 32'(dout));
    chk({tag, ".busy"}, 32'(busy_a), 32'(bsy));
    chk({tag, ".done"}, 32'(done_a), 32'(dn));
  endtask

  task automatic set_data(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    din0 = a; din1 = b; din2 = c; din3 = d;
  endtask

  initial begin
    logic [7:0] exp_b;
    total = 0;
    passed = 0;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    hold_a = 1'b0; hold_b = 1'b0;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    exp_a("reset", 1'b1, 8'h00, 1'b0, 1'b0);
    chk("reset_b.data_ready", 32'(dr_b), 32'd1);
    rst = 1'b0;
    tick();

    // 1: back-to-back frame, source data altered after capture
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    start_a = 1'b1;
    tick();
    exp_a("t1.cap", 1'b1, 8'h00, 1'b1, 1'b0);
    start_a = 1'b0;
    set_data(8'h55, 8'h66, 8'h77, 8'h88);
    tick(); exp_a("t1.b0", 1'b0, 8'h11, 1'b1, 1'b0);
    tick(); exp_a("t1.b1", 1'b0, 8'h22, 1'b1, 1'b0);
    tick(); exp_a("t1.b2", 1'b0, 8'h33, 1'b1, 1'b0);
    tick(); exp_a("t1.b3", 1'b0, 8'h44, 1'b1, 1'b0);
    tick(); exp_a("t1.done", 1'b1, 8'h44, 1'b0, 1'b1);
    tick(); exp_a("t1.idle", 1'b1, 8'h44, 1'b0, 1'b0);

    // 2: GAP=2 frame on instance b
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    start_b = 1'b1;
    tick();
    chk("t2.cap.busy", 32'(busy_b), 32'd1);
    start_b = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k < 4) exp_b = 8'h11;
      else if (k < 7) exp_b = 8'h22;
      else if (k < 10) exp_b = 8'h33;
      else exp_b = 8'h44;
      chk($sformatf("t2.c%0d.data_ready", k), 32'(dr_b),
          32'((k == 1 || k == 4 || k == 7 || k == 10) ? 1'b0 : 1'b1));
      chk($sformatf("t2.c%0d.dataout", k), 32'(dout_b), 32'(exp_b));
      chk($sformatf("t2.c%0d.done", k), 32'(done_b), 32'(k == 11));
    end
    tick();
    chk("t2.idle.done", 32'(done_b), 32'd0);

    // 3: hold for three cycles after byte1
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); exp_a("t3.b0", 1'b0, 8'h11, 1'b1, 1'b0);
    tick(); exp_a("t3.b1", 1'b0, 8'h22, 1'b1, 1'b0);
    hold_a = 1'b1;
    tick(); exp_a("t3.h1", 1'b1, 8'h22, 1'b1, 1'b0);
    tick(); exp_a("t3.h2", 1'b1, 8'h22, 1'b1, 1'b0);
    tick(); exp_a("t3.h3", 1'b1, 8'h22, 1'b1, 1'b0);
    hold_a = 1'b0;
    tick(); exp_a("t3.b2", 1'b0, 8'h33, 1'b1, 1'b0);
    tick(); exp_a("t3.b3", 1'b0, 8'h44, 1'b1, 1'b0);
    tick(); exp_a("t3.done", 1'b1, 8'h44, 1'b0, 1'b1);
    tick();

    // 4: start while busy ignored, start during done accepted
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); exp_a("t4.b0", 1'b0, 8'h11, 1'b1, 1'b0);
    tick(); exp_a("t4.b1", 1'b0, 8'h22, 1'b1, 1'b0);
    start_a = 1'b1;
    set_data(8'h99, 8'h99, 8'h99, 8'h99);
    tick(); exp_a("t4.b2", 1'b0, 8'h33, 1'b1, 1'b0);
    tick(); exp_a("t4.b3", 1'b0, 8'h44, 1'b1, 1'b0);
    start_a = 1'b0;
    tick(); exp_a("t4.done", 1'b1, 8'h44, 1'b0, 1'b1);
    start_a = 1'b1;
    set_data(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    tick(); exp_a("t4.cap2", 1'b1, 8'h44, 1'b1, 1'b0);
    start_a = 1'b0;
    tick(); exp_a("t4.aa", 1'b0, 8'hAA, 1'b1, 1'b0);
    tick(); exp_a("t4.bb", 1'b0, 8'hBB, 1'b1, 1'b0);
    tick(); exp_a("t4.cc", 1'b0, 8'hCC, 1'b1, 1'b0);
    tick(); exp_a("t4.dd", 1'b0, 8'hDD, 1'b1, 1'b0);
    tick(); exp_a("t4.done2", 1'b1, 8'hDD, 1'b0, 1'b1);
    tick();

    // 5: reset during byte2 strobe, then a fresh frame
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    tick(); exp_a("t5.b2", 1'b0, 8'h33, 1'b1, 1'b0);
    rst = 1'b1;
    tick(); exp_a("t5.rst", 1'b1, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); exp_a("t5.post", 1'b1, 8'h00, 1'b0, 1'b0);
    set_data(8'h01, 8'h02, 8'h03, 8'h04);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); exp_a("t5.f0", 1'b0, 8'h01, 1'b1, 1'b0);
    tick(); exp_a("t5.f1", 1'b0, 8'h02, 1'b1, 1'b0);
    tick(); exp_a("t5.f2", 1'b0, 8'h03, 1'b1, 1'b0);
    tick(); exp_a("t5.f3", 1'b0, 8'h04, 1'b1, 1'b0);
    tick(); exp_a("t5.done", 1'b1, 8'h04, 1'b0, 1'b1);
    tick();

    // 6: reset and start on the same edge
    rst = 1'b1;
    start_a = 1'b1;
    tick(); exp_a("t6.rst", 1'b1, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    start_a = 1'b0;
    tick(); exp_a("t6.idle1", 1'b1, 8'h00, 1'b0, 1'b0);
    tick(); exp_a("t6.idle2", 1'b1, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
